// File: rtl/handshake_constant_seq_pkg.sv
// Shared definitions for the constant-sequence handshake block.
// Holds the index-width helpers and the WRAP/SATURATE mode encodings.
package handshake_constant_seq_pkg;

  localparam bit WRAP_MODE     = 1'b1;
  localparam bit SATURATE_MODE = 1'b0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A single-entry table still gets a 1-bit index so the port never collapses.
  function automatic int idx_width(input int depth);
    return clog2((depth < 2) ? 2 : depth);
  endfunction

endpackage

// File: rtl/handshake_oreg.sv
// One-entry valid/ready output register with full throughput.
// The only combinational path is out_ready -> in_ready.
module handshake_oreg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (in_valid && in_ready) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/handshake_constant_seq.sv
// Emits one entry of a parameter-defined constant table per accepted control token,
// in table order, through a one-entry registered output stage.
module handshake_constant_seq
  import handshake_constant_seq_pkg::*;
#(
  parameter int                          DATA_WIDTH  = 32,
  parameter int                          DEPTH       = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0] CONST_TABLE = '0,
  parameter bit                          WRAP        = WRAP_MODE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         restart,
  input  logic                         ctrl_valid,
  output logic                         ctrl_ready,
  output logic [DATA_WIDTH-1:0]        outs,
  output logic                         outs_valid,
  input  logic                         outs_ready,
  output logic [idx_width(DEPTH)-1:0]  idx
);

  localparam int              IDX_W    = idx_width(DEPTH);
  localparam int              SLOTS    = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0]      idx_reg;
  logic [IDX_W-1:0]      idx_next;
  logic [IDX_W-1:0]      idx_eff;
  logic                  accept;
  logic [DATA_WIDTH-1:0] table_entry [SLOTS];

  // Unreachable slots are tied to zero so the select is a full power-of-two mux.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_table
      if (gi < DEPTH) begin : g_used
        assign table_entry[gi] = CONST_TABLE[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_pad
        assign table_entry[gi] = '0;
      end
    end
  endgenerate

  assign accept = ctrl_valid && ctrl_ready;
  assign idx    = idx_reg;

  always_comb begin
    idx_eff  = restart ? '0 : idx_reg;
    idx_next = idx_reg;
    if (accept) begin
      if (idx_eff == LAST_IDX) begin
        idx_next = (WRAP == WRAP_MODE) ? '0 : LAST_IDX;
      end else begin
        idx_next = idx_eff + 1'b1;
      end
    end else if (restart) begin
      idx_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg <= '0;
    end else begin
      idx_reg <= idx_next;
    end
  end

  handshake_oreg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_oreg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ctrl_valid),
    .in_ready (ctrl_ready),
    .in_data  (table_entry[idx_eff]),
    .out_valid(outs_valid),
    .out_ready(outs_ready),
    .out_data (outs)
  );

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Scoreboard bench: a wrapping and a saturating instance share one stimulus stream;
// expected tokens are queued at issue time and a negedge monitor pops and compares.
module tb_handshake_constant_seq;
  import handshake_constant_seq_pkg::*;

  localparam int DW    = 21;
  localparam int DEPTH = 3;
  localparam int IW    = idx_width(DEPTH);
  localparam logic [DEPTH*DW-1:0] TABLE = {21'h000033, 21'h000022, 21'h000011};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic restart = 1'b0;
  logic ctrl_valid = 1'b0;
  logic outs_ready = 1'b0;

  logic          ctrl_ready_w, outs_valid_w, ctrl_ready_s, outs_valid_s;
  logic [DW-1:0] outs_w, outs_s;
  logic [IW-1:0] idx_w, idx_s;

  always #5 clk = ~clk;

  handshake_constant_seq #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .CONST_TABLE(TABLE), .WRAP(WRAP_MODE)
  ) dut_w (
    .clk(clk), .rst(rst), .restart(restart), .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready_w), .outs(outs_w), .outs_valid(outs_valid_w),
    .outs_ready(outs_ready), .idx(idx_w)
  );

  handshake_constant_seq #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .CONST_TABLE(TABLE), .WRAP(SATURATE_MODE)
  ) dut_s (
    .clk(clk), .rst(rst), .restart(restart), .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready_s), .outs(outs_s), .outs_valid(outs_valid_s),
    .outs_ready(outs_ready), .idx(idx_s)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q_w[$];
  logic [DW-1:0] q_s[$];
  logic [DW-1:0] tbl [DEPTH];
  logic [DW-1:0] seq_w [5];
  logic [DW-1:0] seq_s [5];

  // Model state (after the most recent edge) and the expectations for the current cycle.
  logic m_valid = 1'b0;
  int   m_idx_w = 0;
  int   m_idx_s = 0;
  logic exp_valid = 1'b0;
  logic exp_ready = 1'b1;
  int   exp_idx_w = 0;
  int   exp_idx_s = 0;
  logic monitor_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic step(input logic v, input logic r, input logic rs,
                      input logic [DW-1:0] ew, input logic [DW-1:0] es, input bit use_model);
    logic acc;
    int   eff_w, eff_s;
    ctrl_valid = v;
    outs_ready = r;
    restart    = rs;
    exp_valid  = m_valid;
    exp_ready  = !m_valid || r;
    exp_idx_w  = m_idx_w;
    exp_idx_s  = m_idx_s;
    acc   = v && exp_ready;
    eff_w = rs ? 0 : m_idx_w;
    eff_s = rs ? 0 : m_idx_s;
    if (acc) begin
      q_w.push_back(use_model ? tbl[eff_w] : ew);
      q_s.push_back(use_model ? tbl[eff_s] : es);
      m_idx_w = (eff_w == DEPTH - 1) ? 0 : eff_w + 1;
      m_idx_s = (eff_s == DEPTH - 1) ? DEPTH - 1 : eff_s + 1;
      m_valid = 1'b1;
    end else begin
      if (rs) begin
        m_idx_w = 0;
        m_idx_s = 0;
      end
      if (r) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    check("rst_valid_w", 32'(outs_valid_w), 32'd0);
    check("rst_outs_w",  32'(outs_w),       32'd0);
    check("rst_idx_w",   32'(idx_w),        32'd0);
    check("rst_valid_s", 32'(outs_valid_s), 32'd0);
    check("rst_idx_s",   32'(idx_s),        32'd0);
    q_w.delete();
    q_s.delete();
    m_valid = 1'b0;
    m_idx_w = 0;
    m_idx_s = 0;
    ctrl_valid = 1'b0;
    outs_ready = 1'b0;
    restart    = 1'b0;
    @(posedge clk);
    #1;
    rst        = 1'b1;
    exp_valid  = 1'b0;
    exp_ready  = 1'b1;
    exp_idx_w  = 0;
    exp_idx_s  = 0;
    monitor_on = 1'b1;
  endtask

  // Monitor: per-cycle handshake/idx checks, token scoreboard and hold-under-stall check.
  initial begin
    logic          stall_w, stall_s;
    logic [DW-1:0] held_w, held_s, exp_d;
    stall_w = 1'b0;
    stall_s = 1'b0;
    held_w  = '0;
    held_s  = '0;
    forever begin
      @(negedge clk);
      if (!rst || !monitor_on) begin
        stall_w = 1'b0;
        stall_s = 1'b0;
      end else begin
        check("valid_w", 32'(outs_valid_w), 32'(exp_valid));
        check("valid_s", 32'(outs_valid_s), 32'(exp_valid));
        check("ready_w", 32'(ctrl_ready_w), 32'(exp_ready));
        check("ready_s", 32'(ctrl_ready_s), 32'(exp_ready));
        check("idx_w",   32'(idx_w),        32'(exp_idx_w));
        check("idx_s",   32'(idx_s),        32'(exp_idx_s));
        if (stall_w) check("hold_w", 32'(outs_w), 32'(held_w));
        if (stall_s) check("hold_s", 32'(outs_s), 32'(held_s));
        if (outs_valid_w && outs_ready) begin
          if (q_w.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL fire_w: got unexpected token 0x%0h, required none", outs_w);
          end else begin
            exp_d = q_w.pop_front();
            check("fire_w", 32'(outs_w), 32'(exp_d));
          end
        end
        if (outs_valid_s && outs_ready) begin
          if (q_s.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL fire_s: got unexpected token 0x%0h, required none", outs_s);
          end else begin
            exp_d = q_s.pop_front();
            check("fire_s", 32'(outs_s), 32'(exp_d));
          end
        end
        stall_w = outs_valid_w && !outs_ready;
        stall_s = outs_valid_s && !outs_ready;
        held_w  = outs_w;
        held_s  = outs_s;
      end
    end
  end

  initial begin
    tbl[0] = 21'h11; tbl[1] = 21'h22; tbl[2] = 21'h33;
    seq_w = '{21'h11, 21'h22, 21'h33, 21'h11, 21'h22};
    seq_s = '{21'h11, 21'h22, 21'h33, 21'h33, 21'h33};
    @(posedge clk);
    #1;
    do_reset();

    // Continuous flow: wrap vs saturate.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, seq_w[i], seq_s[i], 1'b0);
    check("flow_idx_w", 32'(idx_w), 32'd2);
    check("flow_idx_s", 32'(idx_s), 32'd2);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Backpressure with 22 held.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 21'h11, 21'h11, 1'b0);
    step(1'b1, 1'b1, 1'b0, 21'h22, 21'h22, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    check("stall_outs_w",  32'(outs_w),       32'h22);
    check("stall_ready_w", 32'(ctrl_ready_w), 32'd0);
    check("stall_idx_w",   32'(idx_w),        32'd2);
    step(1'b1, 1'b1, 1'b0, 21'h33, 21'h33, 1'b0);
    check("after_stall_w", 32'(outs_w), 32'h33);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Restart with and without a concurrent accept.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 21'h11, 21'h11, 1'b0);
    step(1'b1, 1'b1, 1'b0, 21'h22, 21'h22, 1'b0);
    step(1'b1, 1'b1, 1'b1, 21'h11, 21'h11, 1'b0);
    check("rs_acc_idx_w", 32'(idx_w), 32'd1);
    check("rs_acc_idx_s", 32'(idx_s), 32'd1);
    step(1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    check("rs_only_idx_w",   32'(idx_w),        32'd0);
    check("rs_only_outs_w",  32'(outs_w),       32'h11);
    check("rs_only_valid_w", 32'(outs_valid_w), 32'd1);
    step(1'b1, 1'b1, 1'b0, 21'h11, 21'h11, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Reset mid-stream discards the held token.
    step(1'b1, 1'b1, 1'b0, 21'h11, 21'h11, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    check("pre_rst_valid_w", 32'(outs_valid_w), 32'd1);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 21'h11, 21'h11, 1'b0);
    check("post_rst_outs_w", 32'(outs_w), 32'h11);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Random valid/ready/restart against the model.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, '0, '0, 1'b1);
    end
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    monitor_on = 1'b0;
    check("drain_w", 32'(q_w.size()), 32'd0);
    check("drain_s", 32'(q_s.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handshake_constant_seq.md
HANDSHAKE_CONSTANT_SEQ -- requirements
Module: handshake_constant_seq

Interface
REQ-001 DATA_WIDTH, 32: width of each emitted constant, 1..64.
REQ-002 DEPTH, 4: number of table entries, 1..256.
REQ-003 CONST_TABLE, all zeros: packed DEPTH*DATA_WIDTH; entry i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-004 WRAP, 1: 1 = index wraps DEPTH-1 -> 0; 0 = index saturates at DEPTH-1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset; low = reset asserted.
REQ-007 restart  input  1  synchronous request to return the table index to 0.
REQ-008 ctrl_valid  input  1  control token offered.
REQ-009 ctrl_ready  output  1  control token accepted when high together with ctrl_valid.
REQ-010 outs  output  DATA_WIDTH  registered constant.
REQ-011 outs_valid  output  1  outs holds a token.
REQ-012 outs_ready  input  1  downstream accepts outs.
REQ-013 idx  output  clog2(max(DEPTH,2))  index of the next entry to be issued (debug/observability).

Function
REQ-014 The block SHALL emit exactly one table entry per accepted control token, in table order starting at entry 0.
REQ-015 The output stage SHALL be a one-entry register; accept = ctrl_valid && ctrl_ready; fire = outs_valid && outs_ready.
REQ-016 The block SHALL drive ctrl_ready = !outs_valid || outs_ready, giving full throughput: one token per cycle under continuous ready.
REQ-017 Latency SHALL be 1 cycle: a token accepted at edge N appears on outs/outs_valid after edge N.
REQ-018 On accept, the block SHALL load outs with CONST_TABLE[idx_eff] and set outs_valid; on fire without accept, it SHALL clear outs_valid; otherwise outs and outs_valid SHALL hold.
REQ-019 idx_eff SHALL be 0 when restart=1, else idx.
REQ-020 After accept, idx SHALL become idx_eff+1, or 0 when idx_eff=DEPTH-1 and WRAP=1, or DEPTH-1 when idx_eff=DEPTH-1 and WRAP=0.
REQ-021 restart without accept SHALL set idx to 0 and SHALL NOT alter outs or outs_valid.
REQ-022 restart with accept in the same cycle SHALL emit entry 0 and leave idx = (DEPTH=1 ? 0 : 1).
REQ-023 With DEPTH=1 the block SHALL always emit entry 0, and idx SHALL stay 0.
REQ-024 outs SHALL be stable while outs_valid=1 and outs_ready=0 (no data change under backpressure).
REQ-025 ctrl_valid SHALL NOT combinationally affect outs_valid or outs; the only comb path SHALL be outs_ready -> ctrl_ready.

Reset
REQ-026 While rst=0, the block SHALL force outs_valid=0, outs=0 and idx=0 asynchronously.
REQ-027 A token held in the output register when rst falls SHALL be discarded; the first token after reset SHALL emit entry 0.
REQ-028 Reset deassertion SHALL be synchronised externally; the block SHALL accept a token on the first edge after rst rises.
REQ-029 ctrl_ready SHALL be 1 during reset only insofar as outs_valid=0; no token SHALL be accepted while rst=0.

Structure
REQ-030 A shared package SHALL hold the index-width function clog2 and the WRAP/SATURATE mode constants.
REQ-031 The output register SHALL be a sub-module, handshake_oreg (DATA_WIDTH parameter; in/out valid-ready plus data); the table and index counter SHALL stay in the top.
REQ-032 The table SHALL be pure parameter-driven combinational selection; no RAM inference.

Verification
(Bench parameters: DATA_WIDTH=21, DEPTH=3, table = 0x000011, 0x000022, 0x000033.)
REQ-033 WRAP=1, ctrl_valid and outs_ready held at 1 for 5 cycles -> outs = 11, 22, 33, 11, 22 on consecutive cycles; ctrl_ready stays 1.
REQ-034 WRAP=0, 5 tokens -> outs = 11, 22, 33, 33, 33; idx stays 2.
REQ-035 outs_valid=1 with outs=22, outs_ready low for 4 cycles -> outs holds 22, ctrl_ready=0, idx unchanged; outs_ready high -> 33 on the next cycle.
REQ-036 After 2 tokens, restart together with an accept -> 11 emitted, idx=1; restart alone -> idx=0 and outs unchanged.
REQ-037 rst pulsed low mid-stream with outs_valid=1 -> outs_valid=0 and idx=0 immediately (asynchronously); the first token after release -> 11.
REQ-038 Random valid/ready for 10k cycles against a reference model -> no lost or duplicated tokens, correct order, and a stable outs under stall.
